// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder and the core's store path:
// default MMIO addresses, legal byte-lane write patterns and the address-decode enum.
package dmem_pkg;

  localparam logic [31:0] TOHOST_ADDR_DEFAULT = 32'h8000_0000;
  localparam logic [31:0] MTIME_ADDR_DEFAULT  = 32'h8000_0004;

  // Byte-lane write-enable patterns (WEN_NONE means "no write").
  localparam logic [3:0] WEN_NONE = 4'b0000;
  localparam logic [3:0] WEN_B0   = 4'b0001;
  localparam logic [3:0] WEN_B1   = 4'b0010;
  localparam logic [3:0] WEN_B2   = 4'b0100;
  localparam logic [3:0] WEN_B3   = 4'b1000;
  localparam logic [3:0] WEN_H0   = 4'b0011;
  localparam logic [3:0] WEN_H2   = 4'b1100;
  localparam logic [3:0] WEN_W    = 4'b1111;

  typedef enum logic [1:0] {
    DEC_RAM,
    DEC_TOHOST,
    DEC_MTIME,
    DEC_NONE
  } dec_e;

  // MMIO registers are decoded at word granularity.
  function automatic logic same_word(input logic [31:0] a, input logic [31:0] b);
    return a[31:2] == b[31:2];
  endfunction

endpackage

// File: rtl/dmem_align_chk.sv
// Byte-lane legality check: given the low address bits and the write enables,
// report whether the lane pattern is a naturally aligned byte, half or word.
// An all-zero pattern (no write) is reported as legal.
module dmem_align_chk
  import dmem_pkg::*;
(
  input  logic [1:0] addr_lo,
  input  logic [3:0] wen,
  output logic       legal
);

  // Table of allowed lane patterns for each byte offset within the word.
  always_comb begin
    legal = 1'b0;
    case (addr_lo)
      2'b00:   legal = (wen == WEN_NONE) || (wen == WEN_B0) || (wen == WEN_H0) || (wen == WEN_W);
      2'b01:   legal = (wen == WEN_NONE) || (wen == WEN_B1);
      2'b10:   legal = (wen == WEN_NONE) || (wen == WEN_B2) || (wen == WEN_H2);
      default: legal = (wen == WEN_NONE) || (wen == WEN_B3);
    endcase
  end

endmodule

// File: rtl/data_mem_resp.sv
// Data-memory responder: word RAM with byte-lane writes and zero-latency reads,
// sticky misalignment/range error flags, a TOHOST register and a cycle counter.
module data_mem_resp
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [31:0] TOHOST_ADDR = TOHOST_ADDR_DEFAULT,
  parameter logic [31:0] MTIME_ADDR  = MTIME_ADDR_DEFAULT,
  parameter string       INIT_FILE   = "dmem.hex"
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] d_mem_addr_i,
  input  logic [31:0] d_mem_wdata_i,
  input  logic [3:0]  d_mem_wen_i,
  input  logic        d_mem_ren_i,
  output logic [31:0] d_mem_rdata_o,
  output logic        misalign_err_o,
  output logic        range_err_o,
  output logic [31:0] tohost_o,
  output logic        tohost_valid_o
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) << 2;

  logic [31:0]   mem [DEPTH_WORDS];

  logic [31:0]   offset;
  logic          in_ram;
  dec_e          dec;
  logic [AW-1:0] word_idx;
  logic [31:0]   read_word;
  logic [31:0]   merged_word;
  logic          lanes_legal;
  logic          wr_any;
  logic          ram_we;
  logic          tohost_we;
  logic          misalign_set;
  logic          range_set;

  logic          misalign_reg;
  logic          range_reg;
  logic [31:0]   tohost_reg;
  logic          tohost_valid_reg;
  logic [31:0]   mtime_reg;

  // The 33-bit compare keeps the upper bound correct even when the RAM ends at 4 GiB.
  assign offset    = d_mem_addr_i - BASE_ADDR;
  assign in_ram    = (d_mem_addr_i >= BASE_ADDR) && ({1'b0, offset} < RAM_BYTES);
  assign word_idx  = offset[AW+1:2];
  assign read_word = mem[word_idx];

  // Address decode; RAM takes priority should a region ever overlap the MMIO words.
  always_comb begin
    dec = DEC_NONE;
    if (in_ram)                                 dec = DEC_RAM;
    else if (same_word(d_mem_addr_i, TOHOST_ADDR)) dec = DEC_TOHOST;
    else if (same_word(d_mem_addr_i, MTIME_ADDR))  dec = DEC_MTIME;
  end

  dmem_align_chk u_align_chk (
    .addr_lo (d_mem_addr_i[1:0]),
    .wen     (d_mem_wen_i),
    .legal   (lanes_legal)
  );

  assign wr_any       = |d_mem_wen_i;
  assign ram_we       = (dec == DEC_RAM) && wr_any && lanes_legal;
  assign tohost_we    = (dec == DEC_TOHOST) && (d_mem_wen_i == WEN_W);
  // TOHOST only accepts full-word stores; any narrower store there counts as misaligned.
  assign misalign_set = wr_any && (!lanes_legal || ((dec == DEC_TOHOST) && (d_mem_wen_i != WEN_W)));
  assign range_set    = (dec == DEC_NONE) && (wr_any || d_mem_ren_i);

  // Merge enabled lanes of the store data over the currently stored word.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign merged_word[gi*8 +: 8] = d_mem_wen_i[gi] ? d_mem_wdata_i[gi*8 +: 8]
                                                    : read_word[gi*8 +: 8];
  end

  // RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) mem[word_idx] <= merged_word;
  end

  // Sticky flags, TOHOST capture with its one-cycle valid pulse, and the cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_reg     <= 1'b0;
      range_reg        <= 1'b0;
      tohost_reg       <= 32'h0;
      tohost_valid_reg <= 1'b0;
      mtime_reg        <= 32'h0;
    end else begin
      if (misalign_set) misalign_reg <= 1'b1;
      if (range_set)    range_reg    <= 1'b1;
      if (tohost_we)    tohost_reg   <= d_mem_wdata_i;
      tohost_valid_reg <= tohost_we;
      mtime_reg        <= mtime_reg + 32'd1;
    end
  end

  // Zero-latency read mux; a read colliding with a write sees the old word.
  always_comb begin
    d_mem_rdata_o = 32'h0;
    if (rst_n) begin
      case (dec)
        DEC_RAM:   d_mem_rdata_o = read_word;
        DEC_MTIME: d_mem_rdata_o = mtime_reg;
        default:   d_mem_rdata_o = 32'h0;
      endcase
    end
  end

  assign misalign_err_o = misalign_reg;
  assign range_err_o    = range_reg;
  assign tohost_o       = tohost_reg;
  assign tohost_valid_o = tohost_valid_reg;

endmodule

// File: tb/tb_data_mem_resp.sv
// Self-checking bench for data_mem_resp: directed vector table, hand-written
// multi-cycle sequences, then randomized traffic against a behavioural model.
module tb_data_mem_resp;

  localparam int          DEPTH = 4096;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam logic [31:0] TOH   = 32'h8000_0000;
  localparam logic [31:0] MT    = 32'h8000_0004;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] d_mem_addr_i = '0;
  logic [31:0] d_mem_wdata_i = '0;
  logic [3:0]  d_mem_wen_i = '0;
  logic        d_mem_ren_i = 1'b0;
  logic [31:0] d_mem_rdata_o;
  logic        misalign_err_o;
  logic        range_err_o;
  logic [31:0] tohost_o;
  logic        tohost_valid_o;

  data_mem_resp dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .d_mem_addr_i   (d_mem_addr_i),
    .d_mem_wdata_i  (d_mem_wdata_i),
    .d_mem_wen_i    (d_mem_wen_i),
    .d_mem_ren_i    (d_mem_ren_i),
    .d_mem_rdata_o  (d_mem_rdata_o),
    .misalign_err_o (misalign_err_o),
    .range_err_o    (range_err_o),
    .tohost_o       (tohost_o),
    .tohost_valid_o (tohost_valid_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One bus transaction: drive, sample the combinational read mid-cycle, pass the edge.
  task automatic cycle(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] we,
                       input logic re, output logic [31:0] rd);
    d_mem_addr_i  = a;
    d_mem_wdata_i = wd;
    d_mem_wen_i   = we;
    d_mem_ren_i   = re;
    @(negedge clk);
    rd = d_mem_rdata_o;
    @(posedge clk);
    #1;
    $display("txn addr=%08h wdata=%08h wen=%b ren=%b rdata=%08h mis=%b rng=%b tohost=%08h tv=%b",
             a, wd, we, re, rd, misalign_err_o, range_err_o, tohost_o, tohost_valid_o);
    d_mem_wen_i = 4'b0000;
    d_mem_ren_i = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_mem [int];
  logic        m_mis, m_rng, m_tv;
  logic [31:0] m_toh;

  // Legal store = naturally aligned contiguous run of 1, 2 or 4 bytes starting at addr[1:0].
  function automatic logic legal_wen(input logic [1:0] lo, input logic [3:0] we);
    int n;
    n = $countones(we);
    if (we == 4'b0000) return 1'b1;
    if (!(n == 1 || n == 2 || n == 4)) return 1'b0;
    if ((int'(lo) % n) != 0) return 1'b0;
    return we == 4'(((1 << n) - 1) << int'(lo));
  endfunction

  function automatic logic m_in_ram(input logic [31:0] a);
    longint ua;
    ua = longint'(a);
    return (ua >= longint'(BASE)) && (ua < longint'(BASE) + 4 * DEPTH);
  endfunction

  // Apply one transaction to the model; returns expected read and whether to check it.
  task automatic model_step(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] we,
                            input logic re, output logic [31:0] exp_rd, output logic chk_rd);
    logic ram, toh, mt, wr, lg;
    int   idx;
    logic [31:0] w;
    ram = m_in_ram(a);
    toh = !ram && (a[31:2] == TOH[31:2]);
    mt  = !ram && (a[31:2] == MT[31:2]);
    wr  = (we != 4'b0000);
    lg  = legal_wen(a[1:0], we);
    idx = int'((a - BASE) >> 2);
    exp_rd = 32'h0;
    chk_rd = 1'b1;
    if (ram) begin
      if (m_mem.exists(idx)) exp_rd = m_mem[idx];
      else chk_rd = 1'b0;
    end else if (mt) begin
      chk_rd = 1'b0;
    end
    if (wr && (!lg || (toh && we != 4'hF))) m_mis = 1'b1;
    if (!ram && !toh && !mt && (wr || re)) m_rng = 1'b1;
    if (ram && wr && lg) begin
      w = m_mem.exists(idx) ? m_mem[idx] : 32'h0;
      for (int k = 0; k < 4; k++)
        if (we[k]) w[k*8 +: 8] = wd[k*8 +: 8];
      m_mem[idx] = w;
    end
    m_tv = toh && (we == 4'hF);
    if (m_tv) m_toh = wd;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wen;
    logic        ren;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_mis;
    logic        exp_rng;
    string       name;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [31:0] rd, rd1, rd2, exp_rd, a, wd;
    logic [3:0]  we;
    logic        re, chk;
    int          n;

    // Directed table: word store, byte/half lanes, read-during-write, misaligned store.
    vecs.push_back('{32'h10, 32'hDEADBEEF, 4'b1111, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, "word_wr"});
    vecs.push_back('{32'h10, 32'h0,        4'b0000, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, "word_rd"});
    vecs.push_back('{32'h13, 32'h55000000, 4'b1000, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, "b3_wr_old"});
    vecs.push_back('{32'h10, 32'h0,        4'b0000, 1'b1, 1'b1, 32'h55ADBEEF, 1'b0, 1'b0, "b3_rd"});
    vecs.push_back('{32'h12, 32'h12340000, 4'b1100, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, "h2_wr"});
    vecs.push_back('{32'h12, 32'h0,        4'b0000, 1'b1, 1'b1, 32'h1234BEEF, 1'b0, 1'b0, "h2_rd"});
    vecs.push_back('{32'h11, 32'h0000FFFF, 4'b0011, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, "mis_wr"});
    vecs.push_back('{32'h10, 32'h0,        4'b0000, 1'b1, 1'b1, 32'h1234BEEF, 1'b1, 1'b0, "mis_rd"});

    // Reset state, with an asynchronous reset edge before any clock.
    #1 rst_n = 1'b0;
    d_mem_addr_i = MT;
    d_mem_ren_i  = 1'b1;
    #1;
    check("rst_rdata", d_mem_rdata_o, 32'h0);
    check("rst_mis", misalign_err_o, 1'b0);
    check("rst_rng", range_err_o, 1'b0);
    check("rst_tohost", tohost_o, 32'h0);
    check("rst_tv", tohost_valid_o, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      cycle(vecs[i].addr, vecs[i].wdata, vecs[i].wen, vecs[i].ren, rd);
      if (vecs[i].chk_rd) check({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rd);
      check({vecs[i].name, "_mis"}, misalign_err_o, vecs[i].exp_mis);
      check({vecs[i].name, "_rng"}, range_err_o, vecs[i].exp_rng);
    end

    repeat (10) cycle(32'h0, 32'h0, 4'b0000, 1'b0, rd);
    check("mis_sticky", misalign_err_o, 1'b1);

    // TOHOST: single write pulse, then back-to-back writes.
    cycle(TOH, 32'h1, 4'b1111, 1'b0, rd);
    check("toh_rd_zero", rd, 32'h0);
    check("toh_val", tohost_o, 32'h1);
    check("toh_tv1", tohost_valid_o, 1'b1);
    cycle(32'h0, 32'h0, 4'b0000, 1'b0, rd);
    check("toh_tv_drop", tohost_valid_o, 1'b0);
    check("toh_hold", tohost_o, 32'h1);
    cycle(TOH, 32'hAAAA0001, 4'b1111, 1'b0, rd);
    check("toh_b2b1_tv", tohost_valid_o, 1'b1);
    check("toh_b2b1_val", tohost_o, 32'hAAAA0001);
    cycle(TOH, 32'hBBBB0002, 4'b1111, 1'b0, rd);
    check("toh_b2b2_tv", tohost_valid_o, 1'b1);
    check("toh_b2b2_val", tohost_o, 32'hBBBB0002);

    // MTIME: consecutive reads step by one; writes there are silently ignored.
    cycle(MT, 32'h0, 4'b0000, 1'b1, rd1);
    cycle(MT, 32'h0, 4'b0000, 1'b1, rd2);
    check("mtime_step", rd2 - rd1, 32'h1);
    cycle(MT, 32'hFFFF0000, 4'b1111, 1'b0, rd);
    cycle(MT, 32'h0, 4'b0000, 1'b1, rd);
    check("mtime_wr_ign", rd - rd2, 32'h2);
    check("mtime_wr_norng", range_err_o, 1'b0);

    // Asynchronous reset mid-cycle while tohost_valid is high.
    cycle(TOH, 32'hCAFE0003, 4'b1111, 1'b0, rd);
    d_mem_addr_i = MT;
    d_mem_ren_i  = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("arst_mtime", d_mem_rdata_o, 32'h0);
    check("arst_tohost", tohost_o, 32'h0);
    check("arst_tv", tohost_valid_o, 1'b0);
    check("arst_mis", misalign_err_o, 1'b0);
    check("arst_rng", range_err_o, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Partial-lane store to TOHOST counts as misaligned and is not latched.
    cycle(TOH, 32'h77, 4'b0001, 1'b0, rd);
    check("toh_part_mis", misalign_err_o, 1'b1);
    check("toh_part_val", tohost_o, 32'h0);
    check("toh_part_tv", tohost_valid_o, 1'b0);
    pulse_reset();

    // Range boundary: last RAM word is in range, the next word is not and must not alias.
    cycle(32'h0, 32'hA5A55A5A, 4'b1111, 1'b0, rd);
    cycle(32'h3FFC, 32'h0BADF00D, 4'b1111, 1'b0, rd);
    cycle(32'h3FFC, 32'h0, 4'b0000, 1'b1, rd);
    check("last_word_rd", rd, 32'h0BADF00D);
    check("last_word_rng", range_err_o, 1'b0);
    cycle(BASE + 4 * DEPTH, 32'h0, 4'b0000, 1'b1, rd);
    check("oor_rd", rd, 32'h0);
    check("oor_rng", range_err_o, 1'b1);
    cycle(BASE + 4 * DEPTH, 32'hFFFFFFFF, 4'b1111, 1'b0, rd);
    cycle(32'h0, 32'h0, 4'b0000, 1'b1, rd);
    check("oor_no_alias", rd, 32'hA5A55A5A);

    // Randomized traffic against the model, with periodic resets to re-arm the sticky flags.
    for (int blk = 0; blk < 4; blk++) begin
      pulse_reset();
      m_mis = 1'b0; m_rng = 1'b0; m_tv = 1'b0; m_toh = 32'h0;
      for (int w = 0; w < 8; w++) begin
        a  = 32'h100 + 32'(w * 4);
        wd = $urandom;
        model_step(a, wd, 4'hF, 1'b0, exp_rd, chk);
        cycle(a, wd, 4'hF, 1'b0, rd);
      end
      model_step(32'h3FFC, 32'h13579BDF, 4'hF, 1'b0, exp_rd, chk);
      cycle(32'h3FFC, 32'h13579BDF, 4'hF, 1'b0, rd);
      for (int t = 0; t < 100; t++) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4: a = 32'h100 + 32'($urandom_range(0, 31));
          5:             a = 32'h3FFC + 32'($urandom_range(0, 3));
          6:             a = TOH;
          7:             a = MT;
          8:             a = 32'h4000 + 32'($urandom_range(0, 255));
          default:       a = 32'h9000_0000 + 32'($urandom_range(0, 15));
        endcase
        wd = $urandom;
        re = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 5))
          0, 1: we = 4'b0000;
          2:    we = 4'($urandom_range(0, 15));
          default: begin
            n = 1 << $urandom_range(0, 2);
            while ((int'(a[1:0]) % n) != 0) n = n / 2;
            we = 4'(((1 << n) - 1) << int'(a[1:0]));
          end
        endcase
        model_step(a, wd, we, re, exp_rd, chk);
        cycle(a, wd, we, re, rd);
        if (chk) check("rnd_rdata", rd, exp_rd);
        check("rnd_mis", misalign_err_o, m_mis);
        check("rnd_rng", range_err_o, m_rng);
        check("rnd_tohost", tohost_o, m_toh);
        check("rnd_tv", tohost_valid_o, m_tv);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound so a stuck run still ends with a report.
  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish before time limit");
    $fatal(1, "timeout");
  end

endmodule
